// File: rtl/si_sal_dachk.sv
// Receive-side destination-address checker: captures the six DA bytes of each
// frame, hashes them with reflected CRC-32 and classifies the address for the filter.
module si_sal_dachk #(
  parameter logic [47:0] PAUSE_DA = 48'h0100_00C2_8001,
  parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        rxfrm_i,
  input  logic        rxbyte_vld_i,
  input  logic [7:0]  rxbyte_i,
  input  logic [47:0] staaddr_i,
  output logic [6:0]  hashv_o,
  output logic        hashe_o,
  output logic        ucad_o,
  output logic        mcad_o,
  output logic        bcad_o,
  output logic        mcadp_o,
  output logic        dat_o
);

  // state | meaning
  // IDLE  | between frames, waiting for rxfrm_i to rise
  // DA    | collecting DA bytes 0..5 and folding them into the CRC
  // DONE  | DA complete, results held, remaining bytes ignored
  typedef enum logic [1:0] {IDLE, DA, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d, crc_base, crc_byte;
  logic [47:0] da_q, da_d, da_full;
  logic [6:0]  hashv_d;
  logic        hashe_d, ucad_d, mcad_d, bcad_d, mcadp_d;

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // The first byte may arrive on the frame-start cycle, before CRC_INIT is loaded.
  assign crc_base = (state_q == IDLE) ? CRC_INIT : crc_q;
  assign crc_byte = crc_upd(crc_base, rxbyte_i);
  assign da_full  = {rxbyte_i, da_q[39:0]};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      da_q    <= '0;
      hashv_o <= '0;
      hashe_o <= 1'b0;
      ucad_o  <= 1'b0;
      mcad_o  <= 1'b0;
      bcad_o  <= 1'b0;
      mcadp_o <= 1'b0;
      dat_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      da_q    <= da_d;
      hashv_o <= hashv_d;
      hashe_o <= hashe_d;
      ucad_o  <= ucad_d;
      mcad_o  <= mcad_d;
      bcad_o  <= bcad_d;
      mcadp_o <= mcadp_d;
      dat_o   <= rxfrm_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    da_d    = da_q;
    hashv_d = hashv_o;
    hashe_d = 1'b0;
    ucad_d  = ucad_o;
    mcad_d  = mcad_o;
    bcad_d  = bcad_o;
    mcadp_d = mcadp_o;
    case (state_q)
      IDLE: begin
        if (rxfrm_i) begin
          state_d = DA;
          cnt_d   = '0;
          crc_d   = CRC_INIT;
          hashv_d = '0;
          ucad_d  = 1'b0;
          mcad_d  = 1'b0;
          bcad_d  = 1'b0;
          mcadp_d = 1'b0;
          if (rxbyte_vld_i) begin
            da_d[7:0] = rxbyte_i;
            crc_d     = crc_byte;
            cnt_d     = 3'd1;
          end
        end
      end
      DA: begin
        if (!rxfrm_i) begin
          state_d = IDLE;
        end else if (rxbyte_vld_i) begin
          da_d[{cnt_q, 3'b000} +: 8] = rxbyte_i;
          crc_d = crc_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            state_d = DONE;
            hashe_d = 1'b1;
            // Filter indexes with the reversed low bits of the final (inverted) CRC.
            hashv_d = ~{crc_byte[0], crc_byte[1], crc_byte[2], crc_byte[3],
                        crc_byte[4], crc_byte[5], crc_byte[6]};
            ucad_d  = (da_full == staaddr_i);
            mcad_d  = da_full[0];
            bcad_d  = (da_full == 48'hFFFF_FFFF_FFFF);
            mcadp_d = (da_full == PAUSE_DA);
          end
        end
      end
      DONE: begin
        if (!rxfrm_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_si_sal_dachk.sv
// Directed self-checking bench for si_sal_dachk: classification, hashing,
// gaps, runts, extra bytes and asynchronous reset.
module tb_si_sal_dachk;
  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        rxfrm_i = 1'b0;
  logic        rxbyte_vld_i = 1'b0;
  logic [7:0]  rxbyte_i = '0;
  logic [47:0] staaddr_i = 48'h5544_3322_1100;
  logic [6:0]  hashv_o;
  logic        hashe_o, ucad_o, mcad_o, bcad_o, mcadp_o, dat_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  localparam logic [47:0] PAUSE = 48'h0100_00C2_8001;
  localparam logic [47:0] STA   = 48'h5544_3322_1100;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  si_sal_dachk dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .rxfrm_i(rxfrm_i),
    .rxbyte_vld_i(rxbyte_vld_i), .rxbyte_i(rxbyte_i), .staaddr_i(staaddr_i),
    .hashv_o(hashv_o), .hashe_o(hashe_o), .ucad_o(ucad_o), .mcad_o(mcad_o),
    .bcad_o(bcad_o), .mcadp_o(mcadp_o), .dat_o(dat_o)
  );

  always #5 clk_i = ~clk_i;

  // Standard bit-serial reflected CRC-32 over the 48 DA bits, wire order.
  function automatic logic [6:0] model_hash(input logic [47:0] d);
    logic [31:0] c;
    logic [6:0]  h;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 48; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    c = ~c;
    for (int j = 0; j < 7; j++) h[j] = c[6-j];
    return h;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (hashe_o === 1'b1) pulses++;
  endtask

  task automatic send_da(input logic [47:0] d, input int gap_idx, input int gap_len);
    rxfrm_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == gap_idx) begin
        rxbyte_vld_i = 1'b0;
        repeat (gap_len) tick();
      end
      rxbyte_i = d[8*i +: 8];
      rxbyte_vld_i = 1'b1;
      tick();
    end
    rxbyte_vld_i = 1'b0;
  endtask

  task automatic end_frame();
    rxfrm_i = 1'b0;
    rxbyte_vld_i = 1'b0;
    tick();
  endtask

  task automatic check_flags(input string nm, input logic u, input logic m,
                             input logic b, input logic p);
    checks++;
    if ({ucad_o, mcad_o, bcad_o, mcadp_o} !== {u, m, b, p}) begin
      errors++;
      $display("FAIL %s flags(u,m,b,p) got %b%b%b%b exp %b%b%b%b", nm,
               ucad_o, mcad_o, bcad_o, mcadp_o, u, m, b, p);
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) tick();
    checks++;
    if ({hashv_o, hashe_o, ucad_o, mcad_o, bcad_o, mcadp_o, dat_o} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {hashv_o, hashe_o, ucad_o, mcad_o, bcad_o, mcadp_o, dat_o});
    end
    reset_ni = 1'b1;
    tick();
  endtask

  task automatic test_pause();
    pulses = 0;
    send_da(PAUSE, -1, 0);
    checks++;
    if (hashe_o !== 1'b1) begin errors++; $display("FAIL pause_hashe got %b exp 1", hashe_o); end
    checks++;
    if (hashv_o !== model_hash(PAUSE)) begin
      errors++; $display("FAIL pause_hashv got %h exp %h", hashv_o, model_hash(PAUSE));
    end
    check_flags("pause", 1'b0, 1'b1, 1'b0, 1'b1);
    // trailing bytes must not produce another strobe
    for (int i = 0; i < 4; i++) begin
      rxbyte_i = 8'(i * 37);
      rxbyte_vld_i = 1'b1;
      tick();
      checks++;
      if (hashe_o !== 1'b0) begin errors++; $display("FAIL pause_extra_hashe got %b exp 0", hashe_o); end
    end
    end_frame();
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL pause_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_bcast();
    send_da(BCAST, -1, 0);
    check_flags("bcast", 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (hashv_o !== model_hash(BCAST)) begin
      errors++; $display("FAIL bcast_hashv got %h exp %h", hashv_o, model_hash(BCAST));
    end
    tick();
    checks++;
    if (hashe_o !== 1'b0) begin errors++; $display("FAIL bcast_strobe_len got %b exp 0", hashe_o); end
    check_flags("bcast_hold", 1'b0, 1'b1, 1'b1, 1'b0);
    end_frame();
    check_flags("bcast_hold_idle", 1'b0, 1'b1, 1'b1, 1'b0);
    rxfrm_i = 1'b1;
    tick();
    check_flags("bcast_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hashv_o !== 7'd0) begin errors++; $display("FAIL bcast_clear_hashv got %h exp 0", hashv_o); end
    end_frame();
  endtask

  task automatic test_gap();
    logic [6:0] h_ref;
    send_da(STA, -1, 0);
    h_ref = hashv_o;
    check_flags("ucast", 1'b1, 1'b0, 1'b0, 1'b0);
    end_frame();
    pulses = 0;
    send_da(STA, 3, 3);
    checks++;
    if (hashe_o !== 1'b1) begin errors++; $display("FAIL gap_hashe got %b exp 1", hashe_o); end
    check_flags("gap", 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hashv_o !== h_ref || hashv_o !== model_hash(STA)) begin
      errors++; $display("FAIL gap_hashv got %h exp %h", hashv_o, model_hash(STA));
    end
    end_frame();
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL gap_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_runt();
    pulses = 0;
    rxfrm_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rxbyte_i = BCAST[8*i +: 8];
      rxbyte_vld_i = 1'b1;
      tick();
    end
    rxfrm_i = 1'b0;
    rxbyte_vld_i = 1'b0;
    #1;
    checks++;
    if (dat_o !== 1'b1) begin errors++; $display("FAIL runt_dat_before got %b exp 1", dat_o); end
    tick();
    checks++;
    if (dat_o !== 1'b0) begin errors++; $display("FAIL runt_dat_after got %b exp 0", dat_o); end
    // stray valid while idle is ignored
    rxbyte_vld_i = 1'b1;
    tick();
    rxbyte_vld_i = 1'b0;
    tick();
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL runt_pulses got %0d exp 0", pulses); end
    check_flags("runt", 1'b0, 1'b0, 1'b0, 1'b0);
    send_da(PAUSE, -1, 0);
    check_flags("after_runt", 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (hashv_o !== model_hash(PAUSE)) begin
      errors++; $display("FAIL after_runt_hashv got %h exp %h", hashv_o, model_hash(PAUSE));
    end
    end_frame();
  endtask

  task automatic test_random();
    logic [47:0] d;
    for (int f = 0; f < 256; f++) begin
      d = {$urandom, $urandom};
      d = d & 48'hFFFF_FFFF_FFFF;
      pulses = 0;
      send_da(d, (f % 7 == 0) ? 2 : -1, 1);
      checks++;
      if (hashv_o !== model_hash(d) || mcad_o !== d[0]) begin
        errors++;
        $display("FAIL rand_%0d hashv/mcad got %h/%b exp %h/%b", f, hashv_o, mcad_o,
                 model_hash(d), d[0]);
      end
      for (int k = 0; k < int'(f % 4); k++) begin
        rxbyte_i = 8'($urandom);
        rxbyte_vld_i = 1'b1;
        tick();
      end
      end_frame();
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL rand_%0d_pulses got %0d exp 1", f, pulses); end
    end
  endtask

  task automatic test_reset_mid();
    rxfrm_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxbyte_i = STA[8*i +: 8];
      rxbyte_vld_i = 1'b1;
      tick();
    end
    send_da(BCAST, -1, 0);
    end_frame();
    rxfrm_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxbyte_i = STA[8*i +: 8];
      rxbyte_vld_i = 1'b1;
      tick();
    end
    #2;
    reset_ni = 1'b0;
    #1;
    checks++;
    if ({hashv_o, hashe_o, ucad_o, mcad_o, bcad_o, mcadp_o, dat_o} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async got %h exp 0",
               {hashv_o, hashe_o, ucad_o, mcad_o, bcad_o, mcadp_o, dat_o});
    end
    rxfrm_i = 1'b0;
    rxbyte_vld_i = 1'b0;
    pulses = 0;
    tick();
    reset_ni = 1'b1;
    tick();
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL reset_no_hashe got %0d exp 0", pulses); end
    send_da(STA, -1, 0);
    check_flags("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hashv_o !== model_hash(STA)) begin
      errors++; $display("FAIL post_reset_hashv got %h exp %h", hashv_o, model_hash(STA));
    end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_pause();
    test_bcast();
    test_gap();
    test_runt();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
